// File: rtl/mem_stage_dcache_ctrl.sv
// MEM-stage data-cache sequencer: one access for LDR/LDB/STR/STB/TRAP, or pointer-read plus final access for LDI/STI.
// Latency: done one cycle after the final access's resp; a single access answered N cycles after request gives done at N+1.
// Backpressure: holds the pipeline via mem_stall until done; each cache request is held until dcache_resp.
module mem_stage_dcache_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              dcacheR,
    input  logic              dcacheW,
    input  logic              ldi_op,
    input  logic              sti_op,
    input  logic              stb_op,
    input  logic              d_mem_byte_sel,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [ADDR_W-1:0] store_data,
    output logic              dcache_read,
    output logic              dcache_write,
    output logic [ADDR_W-1:0] dcache_address,
    output logic [ADDR_W-1:0] dcache_wdata,
    output logic [1:0]        dcache_byte_enable,
    input  logic              dcache_resp,
    input  logic [ADDR_W-1:0] dcache_rdata,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] mem_rdata,
    output logic              mem_done
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q, data_q, ptr_q, rdata_q;
    logic              rd_q, ldi_q, sti_q, stb_q, ldb_q;

    logic              req;
    logic              indirect;
    logic              acc1_rd;
    logic              byte_acc;
    logic [ADDR_W-1:0] load_val;

    assign req      = valid_in & (dcacheR | dcacheW);
    assign indirect = ldi_q | sti_q;
    assign acc1_rd  = rd_q | indirect;
    // Byte lanes only apply when the first access is also the final one.
    assign byte_acc = (stb_q | ldb_q) & ~indirect;

    always_comb begin
        load_val = dcache_rdata;
        if (ldb_q) begin
            if (addr_q[0])
                load_val = {{(ADDR_W-8){dcache_rdata[15]}}, dcache_rdata[15:8]};
            else
                load_val = {{(ADDR_W-8){dcache_rdata[7]}}, dcache_rdata[7:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            ldi_q   <= 1'b0;
            sti_q   <= 1'b0;
            stb_q   <= 1'b0;
            ldb_q   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= addr_in;
                        data_q <= store_data;
                        rd_q   <= dcacheR;
                        ldi_q  <= ldi_op;
                        sti_q  <= sti_op;
                        stb_q  <= stb_op;
                        ldb_q  <= d_mem_byte_sel;
                    end
                end
                ACC1: begin
                    if (dcache_resp) begin
                        if (indirect)
                            ptr_q <= dcache_rdata;
                        else if (rd_q)
                            rdata_q <= load_val;
                    end
                end
                ACC2: begin
                    if (dcache_resp && ldi_q)
                        rdata_q <= dcache_rdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n            = state;
        dcache_read        = 1'b0;
        dcache_write       = 1'b0;
        dcache_address     = '0;
        dcache_wdata       = '0;
        dcache_byte_enable = 2'b00;
        mem_done           = 1'b0;
        case (state)
            IDLE: begin
                if (req)
                    state_n = ACC1;
            end
            ACC1: begin
                dcache_read  = acc1_rd;
                dcache_write = ~acc1_rd;
                if (byte_acc) begin
                    dcache_address     = addr_q;
                    dcache_byte_enable = addr_q[0] ? 2'b10 : 2'b01;
                    dcache_wdata       = {data_q[7:0], data_q[7:0]};
                end else begin
                    dcache_address     = {addr_q[ADDR_W-1:1], 1'b0};
                    dcache_byte_enable = 2'b11;
                    dcache_wdata       = data_q;
                end
                if (dcache_resp)
                    state_n = indirect ? ACC2 : DONE;
            end
            ACC2: begin
                dcache_read        = ldi_q;
                dcache_write       = sti_q & ~ldi_q;
                dcache_address     = {ptr_q[ADDR_W-1:1], 1'b0};
                dcache_byte_enable = 2'b11;
                dcache_wdata       = data_q;
                if (dcache_resp)
                    state_n = DONE;
            end
            DONE: begin
                mem_done = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign mem_stall = req & (state != DONE);
    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_stage_dcache_ctrl.sv
// Directed bench for mem_stage_dcache_ctrl: vector table of single/indirect accesses plus
// hand sequences for stray responses, valid_in dropping mid-operation and reset in ACC2.
module tb_mem_stage_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, dcacheR, dcacheW, ldi_op, sti_op, stb_op, d_mem_byte_sel;
    logic [15:0] addr_in, store_data;
    logic        dcache_read, dcache_write;
    logic [15:0] dcache_address, dcache_wdata;
    logic [1:0]  dcache_byte_enable;
    logic        dcache_resp;
    logic [15:0] dcache_rdata;
    logic        mem_stall, mem_done;
    logic [15:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_stage_dcache_ctrl #(.ADDR_W(16)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .dcacheR(dcacheR), .dcacheW(dcacheW), .ldi_op(ldi_op), .sti_op(sti_op),
        .stb_op(stb_op), .d_mem_byte_sel(d_mem_byte_sel),
        .addr_in(addr_in), .store_data(store_data),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_byte_enable(dcache_byte_enable),
        .dcache_resp(dcache_resp), .dcache_rdata(dcache_rdata),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata), .mem_done(mem_done)
    );

    typedef struct {
        logic        r, w, ldi, sti, stb, ldb;
        logic [15:0] addr, data;
        int          dly;
        logic [15:0] rd1, rd2;
        int          ntx;
        logic [15:0] a1, a2;
        logic        w1, w2;
        logic [1:0]  be;
        logic [15:0] wd;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mkvec(
        input logic r, w, ldi, sti, stb, ldb,
        input logic [15:0] addr, data, input int dly,
        input logic [15:0] rd1, rd2, input int ntx,
        input logic [15:0] a1, a2, input logic w1, w2,
        input logic [1:0] be, input logic [15:0] wd, exp_rdata);
        vec_t v;
        v.r = r; v.w = w; v.ldi = ldi; v.sti = sti; v.stb = stb; v.ldb = ldb;
        v.addr = addr; v.data = data; v.dly = dly; v.rd1 = rd1; v.rd2 = rd2;
        v.ntx = ntx; v.a1 = a1; v.a2 = a2; v.w1 = w1; v.w2 = w2;
        v.be = be; v.wd = wd; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_in = 0; dcacheR = 0; dcacheW = 0; ldi_op = 0; sti_op = 0;
        stb_op = 0; d_mem_byte_sel = 0; addr_in = '0; store_data = '0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          act;
        logic        saw_rd;
        logic        both;
        logic        addr_bad;
        logic [15:0] ea;
        logic        ew;
        saw_rd = 0;
        both = 0;
        @(negedge clk);
        valid_in = 1; dcacheR = v.r; dcacheW = v.w; ldi_op = v.ldi; sti_op = v.sti;
        stb_op = v.stb; d_mem_byte_sel = v.ldb; addr_in = v.addr; store_data = v.data;
        dcache_resp = 0;
        #1;
        chk($sformatf("v%0d stall_first", idx), 32'(mem_stall), 32'd1);
        for (int k = 0; k < v.ntx; k++) begin
            act = 0;
            addr_bad = 0;
            ea = (k == 0) ? v.a1 : v.a2;
            ew = (k == 0) ? v.w1 : v.w2;
            for (int c = 0; c < v.dly; c++) begin
                @(negedge clk);
                dcache_resp  = (c == v.dly - 1);
                dcache_rdata = (k == 0) ? v.rd1 : v.rd2;
                #1;
                if (dcache_read | dcache_write) act++;
                if (dcache_read) saw_rd = 1;
                if (dcache_read & dcache_write) both = 1;
                if (dcache_address !== ea) addr_bad = 1;
            end
            chk($sformatf("v%0d tx%0d req_cycles", idx, k), 32'(act), 32'(v.dly));
            chk($sformatf("v%0d tx%0d addr_stable", idx, k), 32'(addr_bad), 32'd0);
            chk($sformatf("v%0d tx%0d address", idx, k), 32'(dcache_address), 32'(ea));
            chk($sformatf("v%0d tx%0d write", idx, k), 32'(dcache_write), 32'(ew));
            chk($sformatf("v%0d tx%0d read", idx, k), 32'(dcache_read), 32'(!ew));
            if (ew) begin
                chk($sformatf("v%0d tx%0d be", idx, k), 32'(dcache_byte_enable), 32'(v.be));
                chk($sformatf("v%0d tx%0d wdata", idx, k), 32'(dcache_wdata), 32'(v.wd));
            end
        end
        @(negedge clk);
        dcache_resp = 0;
        #1;
        chk($sformatf("v%0d done", idx), 32'(mem_done), 32'd1);
        chk($sformatf("v%0d stall_in_done", idx), 32'(mem_stall), 32'd0);
        chk($sformatf("v%0d req_dropped", idx), 32'(dcache_read | dcache_write), 32'd0);
        chk($sformatf("v%0d mem_rdata", idx), 32'(mem_rdata), 32'(v.exp_rdata));
        chk($sformatf("v%0d both_rw", idx), 32'(both), 32'd0);
        chk($sformatf("v%0d any_read", idx), 32'(saw_rd), 32'((v.ntx == 2) || !v.w1));
        @(negedge clk);
        idle_inputs();
        #1;
        chk($sformatf("v%0d done_one_cycle", idx), 32'(mem_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //                r  w  ldi sti stb ldb addr      data      d  rd1       rd2      n  a1        a2        w1 w2 be     wd        rdata
        vecs[0] = mkvec(1, 0, 0, 0, 0, 0, 16'h1235, 16'h0000, 3, 16'hBEEF, 16'h0, 1, 16'h1234, 16'h0,    0, 0, 2'b00, 16'h0,    16'hBEEF);
        vecs[1] = mkvec(0, 1, 0, 0, 1, 0, 16'h2001, 16'h00A5, 2, 16'h0,    16'h0, 1, 16'h2001, 16'h0,    1, 0, 2'b10, 16'hA5A5, 16'hBEEF);
        vecs[2] = mkvec(1, 0, 0, 0, 0, 1, 16'h3000, 16'h0000, 1, 16'h1280, 16'h0, 1, 16'h3000, 16'h0,    0, 0, 2'b00, 16'h0,    16'hFF80);
        vecs[3] = mkvec(1, 0, 0, 0, 0, 1, 16'h3001, 16'h0000, 2, 16'h1280, 16'h0, 1, 16'h3001, 16'h0,    0, 0, 2'b00, 16'h0,    16'h0012);
        vecs[4] = mkvec(1, 0, 1, 0, 0, 0, 16'h4000, 16'h0000, 2, 16'h5000, 16'h0042, 2, 16'h4000, 16'h5000, 0, 0, 2'b00, 16'h0, 16'h0042);
        vecs[5] = mkvec(0, 1, 0, 1, 0, 0, 16'h6000, 16'h1111, 2, 16'h7002, 16'h0, 2, 16'h6000, 16'h7002, 0, 1, 2'b11, 16'h1111, 16'h0042);
        vecs[6] = mkvec(0, 1, 0, 0, 0, 0, 16'h8003, 16'hCAFE, 1, 16'h0,    16'h0, 1, 16'h8002, 16'h0,    1, 0, 2'b11, 16'hCAFE, 16'h0042);
        vecs[7] = mkvec(1, 0, 1, 0, 0, 0, 16'h4001, 16'h0000, 1, 16'h5003, 16'h8001, 2, 16'h4000, 16'h5002, 0, 0, 2'b00, 16'h0, 16'h8001);
        vecs[8] = mkvec(0, 1, 0, 0, 1, 0, 16'h2000, 16'h12C3, 1, 16'h0,    16'h0, 1, 16'h2000, 16'h0,    1, 0, 2'b01, 16'hC3C3, 16'h8001);

        idle_inputs();
        dcache_resp = 0;
        dcache_rdata = '0;
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        chk("reset read", 32'(dcache_read), 32'd0);
        chk("reset write", 32'(dcache_write), 32'd0);
        chk("reset address", 32'(dcache_address), 32'd0);
        chk("reset be", 32'(dcache_byte_enable), 32'd0);
        chk("reset done", 32'(mem_done), 32'd0);
        chk("reset rdata", 32'(mem_rdata), 32'd0);
        chk("reset stall", 32'(mem_stall), 32'd0);

        // Stray response while idle must be ignored.
        @(negedge clk);
        dcache_resp = 1; dcache_rdata = 16'hFFFF;
        @(negedge clk);
        dcache_resp = 0;
        #1;
        chk("stray_idle done", 32'(mem_done), 32'd0);
        chk("stray_idle read", 32'(dcache_read), 32'd0);
        chk("stray_idle rdata", 32'(mem_rdata), 32'd0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // valid_in drops while ACC1 is outstanding; the load still completes.
        @(negedge clk);
        valid_in = 1; dcacheR = 1; addr_in = 16'h0010;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("vdrop read_held", 32'(dcache_read), 32'd1);
        chk("vdrop stall", 32'(mem_stall), 32'd0);
        chk("vdrop address", 32'(dcache_address), 32'h0010);
        @(negedge clk);
        dcache_resp = 1; dcache_rdata = 16'h7777;
        @(negedge clk);
        dcache_resp = 0;
        #1;
        chk("vdrop done", 32'(mem_done), 32'd1);
        chk("vdrop rdata", 32'(mem_rdata), 32'h7777);
        @(negedge clk);
        #1;
        chk("vdrop done_clear", 32'(mem_done), 32'd0);

        // Reset in ACC2 of an LDI aborts; a later stray resp produces no done.
        @(negedge clk);
        valid_in = 1; dcacheR = 1; ldi_op = 1; addr_in = 16'h4000;
        @(negedge clk);
        dcache_resp = 1; dcache_rdata = 16'h5000;
        @(negedge clk);
        dcache_resp = 0;
        #1;
        chk("rst_acc2 read", 32'(dcache_read), 32'd1);
        chk("rst_acc2 address", 32'(dcache_address), 32'h5000);
        reset = 1;
        idle_inputs();
        @(negedge clk);
        reset = 0;
        dcache_resp = 1; dcache_rdata = 16'h0042;
        #1;
        chk("rst_acc2 read_after", 32'(dcache_read), 32'd0);
        chk("rst_acc2 stall_after", 32'(mem_stall), 32'd0);
        chk("rst_acc2 address_after", 32'(dcache_address), 32'd0);
        chk("rst_acc2 rdata_cleared", 32'(mem_rdata), 32'd0);
        @(negedge clk);
        dcache_resp = 0;
        #1;
        chk("rst_acc2 stray_done", 32'(mem_done), 32'd0);
        @(negedge clk);
        #1;
        chk("rst_acc2 stray_done2", 32'(mem_done), 32'd0);
        chk("rst_acc2 rdata_held", 32'(mem_rdata), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
